// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and default widths.
package cpu_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: write, two reads, issue and busy lookups.
interface regfile_sb_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              busy1;
  logic              busy2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, issue, issue_addr,
    input  rdata1, rdata2, busy1, busy2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, issue, issue_addr,
    output rdata1, rdata2, busy1, busy2
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on the same register.
module regfile_sb_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy_nxt1_c,
  output logic              busy_nxt2_c
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Clear before set so a new producer issued on the same edge keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (we) begin
      busy_nxt[waddr] = 1'b0;
    end
    if (issue) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_nxt[0] = 1'b0;
    end
  end

  assign busy_nxt1_c = busy_nxt[raddr1];
  assign busy_nxt2_c = busy_nxt[raddr2];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, write-to-read bypass and busy scoreboard.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok_c;
  logic              zero1_c;
  logic              zero2_c;
  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;
  logic              busy_nxt1_c;
  logic              busy_nxt2_c;

  regfile_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue       (bus.issue),
    .issue_addr  (bus.issue_addr),
    .we          (bus.we),
    .waddr       (bus.waddr),
    .raddr1      (bus.raddr1),
    .raddr2      (bus.raddr2),
    .busy_nxt1_c (busy_nxt1_c),
    .busy_nxt2_c (busy_nxt2_c)
  );

  assign wr_ok_c = bus.we && !(ZERO_REG && (bus.waddr == '0));
  assign zero1_c = ZERO_REG && (bus.raddr1 == '0);
  assign zero2_c = ZERO_REG && (bus.raddr2 == '0);

  // Read muxes return the post-write value of the addressed register.
  always_comb begin
    rd1_c = mem[bus.raddr1];
    rd2_c = mem[bus.raddr2];
    if (wr_ok_c && (bus.waddr == bus.raddr1)) begin
      rd1_c = bus.wdata;
    end
    if (wr_ok_c && (bus.waddr == bus.raddr2)) begin
      rd2_c = bus.wdata;
    end
    if (zero1_c) begin
      rd1_c = '0;
    end
    if (zero2_c) begin
      rd2_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem        <= '{default: '0};
      bus.rdata1 <= '0;
      bus.rdata2 <= '0;
      bus.busy1  <= 1'b0;
      bus.busy2  <= 1'b0;
    end else begin
      if (wr_ok_c) begin
        mem[bus.waddr] <= bus.wdata;
      end
      bus.rdata1 <= rd1_c;
      bus.rdata2 <= rd2_c;
      bus.busy1  <= busy_nxt1_c;
      bus.busy2  <= busy_nxt2_c;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic vs. an architectural model.
module tb_regfile_sb;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  word_t m_mem  [32];
  bit    m_busy [32];

  regfile_sb_if bus ();

  regfile_sb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model to the post-edge architectural state, compare.
  task automatic cyc(input string tag, input bit r, input bit w, input reg_addr_t wa, input word_t wd,
                     input reg_addr_t a1, input reg_addr_t a2, input bit is, input reg_addr_t ia);
    word_t e1, e2;
    bit    b1, b2;
    rst = r; bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.raddr1 = a1; bus.raddr2 = a2; bus.issue = is; bus.issue_addr = ia;
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (w && wa != 0) m_mem[wa] = wd;
      if (w) m_busy[wa] = 1'b0;
      if (is && ia != 0) m_busy[ia] = 1'b1;
    end
    e1 = (a1 == 0) ? 32'h0 : m_mem[a1];
    e2 = (a2 == 0) ? 32'h0 : m_mem[a2];
    b1 = (a1 == 0) ? 1'b0 : m_busy[a1];
    b2 = (a2 == 0) ? 1'b0 : m_busy[a2];
    @(posedge clk);
    #1;
    check({tag, ".rdata1"}, bus.rdata1, e1);
    check({tag, ".rdata2"}, bus.rdata2, e2);
    check({tag, ".busy1"}, 32'(bus.busy1), 32'(b1));
    check({tag, ".busy2"}, 32'(bus.busy2), 32'(b2));
  endtask

  function automatic reg_addr_t rnd_addr();
    if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, 31));
    return reg_addr_t'($urandom_range(0, 7));
  endfunction

  initial begin
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr1 = '0;
    bus.raddr2 = '0; bus.issue = 1'b0; bus.issue_addr = '0;
    @(negedge clk);

    // Reset, then read r5/r6
    cyc("rst",     1, 0, 0, 0, 5, 6, 0, 0);
    cyc("rst_rd",  0, 0, 0, 0, 5, 6, 0, 0);
    // Write then read
    cyc("wr3",     0, 1, 3, 32'hAA55FFF0, 0, 0, 0, 0);
    cyc("rd3",     0, 0, 0, 0, 3, 1, 0, 0);
    // Same-edge bypass on both ports
    cyc("byp7",    0, 1, 7, 32'h1234, 7, 7, 0, 0);
    // Register 0 hardwired
    cyc("zero_wr", 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
    cyc("zero_rd", 0, 0, 0, 0, 0, 0, 0, 0);
    // Scoreboard on r9
    cyc("iss9",    0, 0, 0, 0, 9, 0, 1, 9);
    cyc("busy9",   0, 0, 0, 0, 9, 9, 0, 0);
    cyc("wb9",     0, 1, 9, 32'h42, 9, 9, 0, 0);
    cyc("isswb9",  0, 1, 9, 32'h77, 9, 9, 1, 9);
    cyc("diff",    0, 1, 9, 32'h99, 9, 10, 1, 10);
    // Reset mid-stream discards state
    cyc("wr4",     0, 1, 4, 32'hDEAD, 4, 0, 0, 0);
    cyc("iss4",    0, 0, 0, 0, 4, 0, 1, 4);
    cyc("mrst",    1, 1, 4, 32'hBEEF, 4, 9, 1, 4);
    cyc("mrst_rd", 0, 0, 0, 0, 4, 9, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cyc("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
          rnd_addr(), rnd_addr(), ($urandom_range(0, 2) == 0), rnd_addr());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
